// File: rtl/sipo_pkg.sv
// sipo_pkg: shared state encoding and direction names for the deserializer
package sipo_pkg;
    typedef enum logic {ST_IDLE, ST_RECV} state_t;
    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";
endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: word holding register with valid/ready handoff and overrun pulse
module sipo_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             po_ready,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    output logic             overrun
);
    logic free;
    assign free = !po_valid || po_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            po       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= word_done && !free;
            if (word_done && free) begin
                po       <= word;
                po_valid <= 1'b1;
            end else if (po_valid && po_ready) begin
                po_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: framed serial-in/parallel-out deserializer feeding a valid/ready holding register
module sipo_deser
    import sipo_pkg::*;
#(
    parameter string SHIFT_DIRECTION = DIR_LEFT,
    parameter int    SHIFT_AMOUNT    = 1,
    parameter int    WIDTH           = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    si_valid,
    input  logic [SHIFT_AMOUNT-1:0] si,
    output logic [WIDTH-1:0]        po,
    output logic                    po_valid,
    input  logic                    po_ready,
    output logic                    busy,
    output logic                    overrun
);
    localparam int BEATS = WIDTH / SHIFT_AMOUNT;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam bit LEFT  = (SHIFT_DIRECTION == DIR_LEFT);
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n, cnt_base;
    logic [WIDTH-1:0] sr, sr_n, base, shifted;
    logic             accept, last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
        end
    end
    // a start strobe restarts from an empty word, so its own beat becomes beat 0
    always_comb begin
        base     = start ? '0 : sr;
        cnt_base = start ? '0 : cnt;
        accept   = si_valid && (start || state == ST_RECV);
        shifted  = LEFT ? {base[WIDTH-SHIFT_AMOUNT-1:0], si} : {si, base[WIDTH-1:SHIFT_AMOUNT]};
        last     = accept && (cnt_base == CW'(BEATS - 1));
        cnt_n    = last ? '0 : (accept ? cnt_base + 1'b1 : cnt_base);
        sr_n     = accept ? shifted : base;
        state_n  = last ? ST_IDLE : (start ? ST_RECV : state);
    end
    assign busy = (state == ST_RECV);
    sipo_out_buf #(.WIDTH(WIDTH)) u_out (
        .clk      (clk),
        .rst      (rst),
        .word     (shifted),
        .word_done(last),
        .po_ready (po_ready),
        .po       (po),
        .po_valid (po_valid),
        .overrun  (overrun)
    );
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: three configurations (LEFT/1, RIGHT/1, LEFT/2) against a beat-list reference model
module tb_sipo_deser;
    logic       clk = 0, rst = 1, start = 0, si_valid = 0, po_ready = 0;
    logic       si1 = 0;
    logic [1:0] si2 = 0;
    logic [7:0] po [3];
    logic       pv [3], bsy [3], ov [3];
    int total = 0, bad = 0;
    int         sa   [3] = '{1, 1, 2};
    bit         left [3] = '{1, 0, 1};
    int         q    [3][$];
    logic [7:0] epo  [3];
    bit         ev [3], eov [3], eb [3];
    always #5 clk = ~clk;
    sipo_deser #(.SHIFT_DIRECTION("LEFT"), .SHIFT_AMOUNT(1), .WIDTH(8)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .si_valid(si_valid), .si(si1),
        .po(po[0]), .po_valid(pv[0]), .po_ready(po_ready), .busy(bsy[0]), .overrun(ov[0]));
    sipo_deser #(.SHIFT_DIRECTION("RIGHT"), .SHIFT_AMOUNT(1), .WIDTH(8)) u_r1 (
        .clk(clk), .rst(rst), .start(start), .si_valid(si_valid), .si(si1),
        .po(po[1]), .po_valid(pv[1]), .po_ready(po_ready), .busy(bsy[1]), .overrun(ov[1]));
    sipo_deser #(.SHIFT_DIRECTION("LEFT"), .SHIFT_AMOUNT(2), .WIDTH(8)) u_l2 (
        .clk(clk), .rst(rst), .start(start), .si_valid(si_valid), .si(si2),
        .po(po[2]), .po_valid(pv[2]), .po_ready(po_ready), .busy(bsy[2]), .overrun(ov[2]));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            epo[k] = 0; ev[k] = 0; eov[k] = 0; eb[k] = 0;
        end
    endtask
    // a frame is the list of beats received since start; the word is built from the list once it is full
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int  b, word;
            bit  done;
            b    = (k == 2) ? int'(si2) : int'(si1);
            done = 0;
            word = 0;
            if (start) begin
                q[k].delete();
                eb[k] = 1;
            end
            if (si_valid && eb[k]) begin
                q[k].push_back(b);
                if (q[k].size() == 8 / sa[k]) begin
                    for (int i = 0; i < q[k].size(); i++)
                        word = left[k] ? word * (1 << sa[k]) + q[k][i] : word + (q[k][i] << (sa[k] * i));
                    q[k].delete();
                    eb[k] = 0;
                    done  = 1;
                end
            end
            eov[k] = 0;
            if (done) begin
                if (ev[k] && !po_ready) eov[k] = 1;
                else begin
                    epo[k] = 8'(word);
                    ev[k]  = 1;
                end
            end else if (ev[k] && po_ready) ev[k] = 0;
        end
    endtask
    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("po%0d", k), po[k], epo[k]);
            chk($sformatf("po_valid%0d", k), pv[k], ev[k]);
            chk($sformatf("busy%0d", k), bsy[k], eb[k]);
            chk($sformatf("overrun%0d", k), ov[k], eov[k]);
        end
    endtask
    task automatic cyc(input bit st, input bit v, input logic s1, input logic [1:0] s2, input bit rdy);
        start = st; si_valid = v; si1 = s1; si2 = s2; po_ready = rdy;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask
    task automatic rnd_frame(input bit rdy);
        cyc(1, 1, 1'($urandom), 2'($urandom), rdy);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1'($urandom), 2'($urandom), rdy);
    endtask
    initial begin
        logic [7:0] bits;
        bits = 8'b1011_0010;
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst = 0;
        // first beat lands in MSB for LEFT, LSB for RIGHT
        cyc(1, 1, bits[7], 0, 0);
        for (int i = 6; i >= 0; i--) cyc(0, 1, bits[i], 0, 0);
        chk("t1_left", po[0], 8'hB2);
        chk("t2_right", po[1], 8'h4D);
        chk("t1_valid", pv[0], 1);
        cyc(0, 0, 0, 0, 1);
        // two-bit beats separated by idle gaps
        cyc(1, 1, 0, 2'b10, 0);
        cyc(0, 0, 1, 2'b11, 0);
        cyc(0, 1, 0, 2'b11, 0);
        cyc(0, 0, 1, 2'b01, 0);
        cyc(0, 1, 0, 2'b00, 0);
        cyc(0, 0, 1, 2'b10, 0);
        cyc(0, 1, 0, 2'b01, 0);
        chk("t3_sa2", po[2], 8'hB1);
        cyc(0, 0, 0, 0, 1);
        // consumer stalled across two frames
        rnd_frame(0);
        rnd_frame(0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t4_drain", pv[0], 0);
        // restart after three beats
        cyc(1, 1, 1, 2'b11, 1);
        cyc(0, 1, 1, 2'b11, 1);
        cyc(0, 1, 1, 2'b11, 1);
        bits = 8'($urandom);
        cyc(1, 1, bits[7], 0, 1);
        for (int i = 6; i >= 0; i--) cyc(0, 1, bits[i], 0, 1);
        chk("t5_restart", po[0], bits);
        // async reset with a held word and a partial frame
        rnd_frame(0);
        cyc(1, 1, 1, 2'b01, 0);
        cyc(0, 1, 0, 2'b10, 0);
        @(negedge clk) rst = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_po%0d", k), po[k], 0);
            chk($sformatf("t6_valid%0d", k), pv[k], 0);
            chk($sformatf("t6_busy%0d", k), bsy[k], 0);
        end
        model_reset();
        @(negedge clk) rst = 0;
        rnd_frame(1);
        cyc(0, 0, 0, 0, 1);
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(15) == 0, $urandom_range(3) != 0, 1'($urandom), 2'($urandom), 1'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
